// File: rtl/if_fetch.sv
// if_fetch -- instruction-fetch stage of the in-order MIPS pipeline.
//
// Issues one SRAM-like read per PC on the instruction bus. While a fetch is
// outstanding it asserts stallreq_o. The returned word, its PC and its
// exception bits are captured into the IF/ID pipeline register. If a flush
// arrives mid-access, the late response is discarded.
//
// Ports
//   clk, rst              pipeline clock, asynchronous active-low reset
//   pc_i, ce_i            fetch address and fetch enable from the PC register
//   excepttype_i          fetch exception vector (bit 16 = AdEL)
//   stall, flush          stall vector (bit 1 = IF/ID) and exception flush
//   inst_req, inst_addr   bus request / address
//   inst_addr_ok          bus request accepted
//   inst_data_ok          bus read data valid
//   inst_rdata            bus read data
//   stallreq_o            hold the pipeline: instruction for pc_i not ready
//   id_*_o                IF/ID pipeline register
//
// state  | meaning
// IDLE   | no access outstanding, request issued when eligible
// WAIT   | request accepted, waiting for data_ok
// HOLD   | data returned while IF/ID stalled, kept in buffer
// CANCEL | flushed mid-access, next data_ok is dropped
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [31:0] excepttype_i,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        stallreq_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_excepttype_o,
  output logic        id_valid_o
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, CANCEL} state_e;

  state_e      state_q, state_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_exc_q, buf_exc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_exc_q, id_exc_d;
  logic        id_valid_q, id_valid_d;

  logic adel;
  logic avail;
  logic unused_stall_bits;

  assign adel              = excepttype_i[16];
  assign unused_stall_bits = ^{stall[5:2], stall[0]};

  // Gated by rst so both outputs read 0 while reset is held, even though the
  // state register already sits in IDLE.
  assign inst_req   = rst & (state_q == IDLE) & ce_i & ~adel & ~flush & ~stall[1];
  assign inst_addr  = pc_i;
  assign stallreq_o = rst & ce_i & ~adel &
                      ((state_q == IDLE) |
                       ((state_q == WAIT) & ~inst_data_ok) |
                       (state_q == CANCEL));

  // An instruction is ready to enter IF/ID this cycle.
  assign avail = ((state_q == WAIT) & inst_data_ok) |
                 (state_q == HOLD) |
                 ((state_q == IDLE) & ce_i & adel);

  always_comb begin
    state_d    = state_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    buf_exc_d  = buf_exc_q;

    unique case (state_q)
      IDLE: begin
        if (inst_req && inst_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        // Flush wins over a coincident data_ok; without data the response
        // is still in flight and must be swallowed in CANCEL.
        if (flush) begin
          state_d = inst_data_ok ? IDLE : CANCEL;
        end else if (inst_data_ok) begin
          if (stall[1]) begin
            buf_pc_d   = pc_i;
            buf_inst_d = inst_rdata;
            buf_exc_d  = excepttype_i;
            state_d    = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          buf_pc_d   = '0;
          buf_inst_d = '0;
          buf_exc_d  = '0;
          state_d    = IDLE;
        end else if (!stall[1]) begin
          state_d = IDLE;
        end
      end
      CANCEL: begin
        if (inst_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_exc_d   = id_exc_q;
    id_valid_d = id_valid_q;

    if (flush) begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_exc_d   = '0;
      id_valid_d = 1'b0;
    end else if (stall[1]) begin
      // hold
    end else if (avail) begin
      id_valid_d = 1'b1;
      if (state_q == HOLD) begin
        id_pc_d   = buf_pc_q;
        id_inst_d = buf_inst_q;
        id_exc_d  = buf_exc_q;
      end else begin
        id_pc_d   = pc_i;
        id_inst_d = (state_q == WAIT) ? inst_rdata : 32'h0;
        id_exc_d  = excepttype_i;
      end
    end else begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_exc_d   = '0;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
      buf_exc_q  <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_exc_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      buf_exc_q  <= buf_exc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_exc_q   <= id_exc_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc_o         = id_pc_q;
  assign id_inst_o       = id_inst_q;
  assign id_excepttype_o = id_exc_q;
  assign id_valid_o      = id_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. Each table row is one clock cycle. Inputs are
// applied just after a rising edge. The combinational outputs are checked
// on the falling edge, and the IF/ID register is checked just after the
// next rising edge.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [31:0] excepttype_i;
  logic [5:0]  stall;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        stallreq_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [31:0] id_excepttype_o;
  logic        id_valid_o;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc_i),
    .ce_i           (ce_i),
    .excepttype_i   (excepttype_i),
    .stall          (stall),
    .flush          (flush),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .stallreq_o     (stallreq_o),
    .id_pc_o        (id_pc_o),
    .id_inst_o      (id_inst_o),
    .id_excepttype_o(id_excepttype_o),
    .id_valid_o     (id_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic [31:0] exc;
    logic        st1;
    logic        fl;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_sreq;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_exc;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(
    input logic ce, input logic [31:0] pc, input logic [31:0] exc,
    input logic st1, input logic fl, input logic aok, input logic dok,
    input logic [31:0] rdata, input logic e_req, input logic e_sreq,
    input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_inst,
    input logic [31:0] e_exc);
    vec_t v;
    v.ce = ce; v.pc = pc; v.exc = exc; v.st1 = st1; v.fl = fl;
    v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.e_req = e_req; v.e_sreq = e_sreq; v.e_vld = e_vld;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_exc = e_exc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      nerr++;
    end
  endtask

  task automatic drive(input vec_t v);
    ce_i         = v.ce;
    pc_i         = v.pc;
    excepttype_i = v.exc;
    stall        = {4'b0, v.st1, v.st1};
    flush        = v.fl;
    inst_addr_ok = v.aok;
    inst_data_ok = v.dok;
    inst_rdata   = v.rdata;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v);
    @(negedge clk);
    chk("inst_req", idx, {31'b0, inst_req}, {31'b0, v.e_req});
    chk("stallreq", idx, {31'b0, stallreq_o}, {31'b0, v.e_sreq});
    chk("inst_addr", idx, inst_addr, v.pc);
    @(posedge clk);
    #1;
    chk("id_valid", idx, {31'b0, id_valid_o}, {31'b0, v.e_vld});
    chk("id_pc", idx, id_pc_o, v.e_pc);
    chk("id_inst", idx, id_inst_o, v.e_inst);
    chk("id_exc", idx, id_excepttype_o, v.e_exc);
    nvec++;
  endtask

  task automatic chk_all_zero(input string tag, input int idx);
    chk({tag, "_req"}, idx, {31'b0, inst_req}, 32'h0);
    chk({tag, "_sreq"}, idx, {31'b0, stallreq_o}, 32'h0);
    chk({tag, "_vld"}, idx, {31'b0, id_valid_o}, 32'h0);
    chk({tag, "_pc"}, idx, id_pc_o, 32'h0);
    chk({tag, "_inst"}, idx, id_inst_o, 32'h0);
    chk({tag, "_exc"}, idx, id_excepttype_o, 32'h0);
    nvec++;
  endtask

  localparam logic [31:0] ADEL = 32'h0001_0000;

  initial begin
    // Cycle script starting in IDLE right after reset release.
    //              ce pc            exc   st fl ak dk rdata          req sr vld pc            inst           exc
    vecs.push_back(mk(0, 32'hbfc00000, 0,    0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00000, 0,    0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00000, 0,    0, 0, 0, 1, 32'h24080001, 0, 0, 1, 32'hbfc00000, 32'h24080001, 0));
    vecs.push_back(mk(1, 32'hbfc00004, 0,    1, 0, 0, 0, 32'h0,        0, 1, 1, 32'hbfc00000, 32'h24080001, 0));
    vecs.push_back(mk(1, 32'hbfc00004, 0,    0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00004, 0,    0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h0,        0));
    // back-pressure: data arrives during IF/ID stall, three stalled cycles
    vecs.push_back(mk(1, 32'hbfc00004, 0,    1, 0, 0, 1, 32'h8c020004, 0, 0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00004, 0,    1, 0, 1, 1, 32'hdeadbeef, 0, 0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00004, 0,    1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00004, 0,    0, 0, 0, 0, 32'h0,        0, 0, 1, 32'hbfc00004, 32'h8c020004, 0));
    // flush mid-access, late response dropped, refetch from handler
    vecs.push_back(mk(1, 32'hbfc00010, 0,    0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00010, 0,    0, 1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00380, 0,    0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00380, 0,    0, 0, 0, 1, 32'h11111111, 0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00380, 0,    0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00380, 0,    0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00380, 0,    0, 0, 0, 1, 32'h3c1d8000, 0, 0, 1, 32'hbfc00380, 32'h3c1d8000, 0));
    // AdEL: no bus cycle, IF/ID loaded at once
    vecs.push_back(mk(1, 32'hbfc00002, ADEL, 0, 0, 1, 0, 32'h0,        0, 0, 1, 32'hbfc00002, 32'h0,        ADEL));
    // flush coinciding with data_ok in WAIT
    vecs.push_back(mk(1, 32'hbfc00008, 0,    0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00008, 0,    0, 1, 0, 1, 32'h22222222, 0, 0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00380, 0,    0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00380, 0,    0, 1, 1, 0, 32'h0,        0, 1, 0, 32'h0,        32'h0,        0));
    // flush while holding a buffered word discards it
    vecs.push_back(mk(1, 32'hbfc00400, 0,    0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00400, 0,    1, 0, 0, 1, 32'h33333333, 0, 0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00400, 0,    1, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00380, 0,    0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0));
    // fetch that leaves IF/ID valid before the reset sequence
    vecs.push_back(mk(1, 32'hbfc00380, 0,    0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 32'hbfc00380, 0,    0, 0, 0, 1, 32'h44444444, 0, 0, 1, 32'hbfc00380, 32'h44444444, 0));

    // Reset held for two cycles with fetch enabled: everything must read 0.
    rst = 1'b0;
    drive(mk(1, 32'hbfc00000, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_all_zero("reset", i);
      @(posedge clk);
    end
    #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Async reset while IF/ID holds a valid word: it clears before any edge.
    drive(mk(1, 32'hbfc00384, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst", 100);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset mid-access: after reset the FSM is back in IDLE and requests again.
    drive(mk(1, 32'hbfc00384, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("pre_rst_req", 101, {31'b0, inst_req}, 32'h1);
    @(posedge clk);
    #1;
    inst_addr_ok = 1'b0;
    @(negedge clk);
    chk("wait_req", 102, {31'b0, inst_req}, 32'h0);
    chk("wait_sreq", 102, {31'b0, stallreq_o}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_sreq", 103, {31'b0, stallreq_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("post_rst_req", 104, {31'b0, inst_req}, 32'h1);
    chk("post_rst_sreq", 104, {31'b0, stallreq_o}, 32'h1);
    chk("post_rst_addr", 104, inst_addr, 32'hbfc00384);
    nvec += 3;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
